// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - multi-digit 7-segment scan controller sharing one hex decoder
module sseg_scan_ctrl #(
    parameter int DIGITS  = 4,
    parameter int BLINK_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_en,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            dec_data,
    input  logic [7:0]            dec_led,
    output logic [8*DIGITS-1:0]   hex
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]              idx_q, idx_d;
    logic [4*DIGITS-1:0]        val_q, val_d;
    logic [DIGITS-1:0]          dp_q, dp_d;
    logic [DIGITS-1:0]          blink_q, blink_d;
    logic [DIGITS-1:0]          lz_q, lz_d;
    logic [3:0]                 dec_data_q, dec_data_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [DIGITS-1:0][7:0]     shadow_q, shadow_d;
    logic [DIGITS-1:0][7:0]     comm_q, comm_d;
    logic [8*DIGITS-1:0]        hex_q, hex_d;
    logic [BLINK_W-1:0]         cnt_q, cnt_d;

    logic [DIGITS-1:0]          lz_new;
    logic [IW-1:0]              next_idx;
    logic                       unused_dec_dp;

    // The decoder's own DP bit is ignored; the DP comes from the dp input.
    assign unused_dec_dp = dec_led[7];
    assign next_idx      = idx_q + 1'b1;

    // Leading-zero mask: walk from the top digit down while every nibble seen so far is zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_new   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero  = all_zero & (value[4*i +: 4] == 4'h0);
            lz_new[i] = blank_lz & all_zero & (i != 0);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one scan cycle per digit, then a single commit cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load) state_d = S_SCAN;
            S_SCAN:   if (idx_q == LAST_IDX) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: latch on accept, capture decoder results, commit all digits together.
    always_comb begin
        idx_d      = idx_q;
        val_d      = val_q;
        dp_d       = dp_q;
        blink_d    = blink_q;
        lz_d       = lz_q;
        dec_data_d = dec_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        shadow_d   = shadow_q;
        comm_d     = comm_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    val_d      = value;
                    dp_d       = dp;
                    blink_d    = blink_en;
                    lz_d       = lz_new;
                    idx_d      = '0;
                    dec_data_d = value[3:0];
                    busy_d     = 1'b1;
                end
            end
            S_SCAN: begin
                shadow_d[idx_q] = {~dp_q[idx_q], lz_q[idx_q] ? 7'h7F : dec_led[6:0]};
                if (idx_q != LAST_IDX) begin
                    idx_d      = next_idx;
                    dec_data_d = val_q[4*int'(next_idx) +: 4];
                end
            end
            S_COMMIT: begin
                comm_d = shadow_q;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Free-running blink counter and the registered, blink-masked pin drive.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        hex_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            hex_d[8*i +: 8] = (blink_q[i] && cnt_q[BLINK_W-1]) ? 8'hFF : comm_q[i];
        end
    end

    // Datapath registers; reset leaves the display dark and aborts any scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            val_q      <= '0;
            dp_q       <= '0;
            blink_q    <= '0;
            lz_q       <= '0;
            dec_data_q <= 4'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shadow_q   <= {DIGITS{8'hFF}};
            comm_q     <= {DIGITS{8'hFF}};
            hex_q      <= {DIGITS{8'hFF}};
            cnt_q      <= '0;
        end else begin
            idx_q      <= idx_d;
            val_q      <= val_d;
            dp_q       <= dp_d;
            blink_q    <= blink_d;
            lz_q       <= lz_d;
            dec_data_q <= dec_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            shadow_q   <= shadow_d;
            comm_q     <= comm_d;
            hex_q      <= hex_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dec_data = dec_data_q;
    assign hex      = hex_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - self-checking bench for sseg_scan_ctrl
module tb_sseg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int BW     = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] value    = 16'h0;
    logic [3:0]  dp       = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_en = 4'h0;
    logic        busy;
    logic        done;
    logic [3:0]  dec_data;
    logic [7:0]  dec_led;
    logic [31:0] hex;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Active-low gfedcba hex font, DP bit off.
    function automatic logic [7:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
        endcase
    endfunction

    assign dec_led = seg(dec_data);

    sseg_scan_ctrl #(.DIGITS(DIGITS), .BLINK_W(BW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .dp       (dp),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .busy     (busy),
        .done     (done),
        .dec_data (dec_data),
        .dec_led  (dec_led),
        .hex      (hex)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected full display for a value, straight from the blanking/DP rules.
    function automatic logic [31:0] display(input logic [15:0] v, input logic [3:0] d, input logic lz);
        logic [31:0] r;
        logic        blanked;
        logic [7:0]  s;
        for (int i = 0; i < DIGITS; i++) begin
            blanked      = lz && (i != 0) && ((v >> (4*i)) == 16'h0);
            s            = seg(v[4*i +: 4]);
            r[8*i +: 8]  = {~d[i], blanked ? 7'h7F : s[6:0]};
        end
        return r;
    endfunction

    // Edge-indexed model: acceptance edge acc, busy for acc..acc+4, done after acc+5,
    // display committed at acc+5 and visible on the pins from acc+6.
    int          k       = 0;
    int          acc     = -100;
    int          ph      = 0;
    logic [31:0] m_comm  = 32'hFFFF_FFFF;
    logic [31:0] m_pend  = 32'hFFFF_FFFF;
    logic [3:0]  m_blink = 4'h0;
    logic [15:0] m_val   = 16'h0;
    logic [31:0] exp_hex = 32'hFFFF_FFFF;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        dd_valid = 1'b0;
    logic [3:0]  exp_dd   = 4'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        = 0;
            acc      = -100;
            m_comm   = 32'hFFFF_FFFF;
            m_blink  = 4'h0;
            exp_hex  = 32'hFFFF_FFFF;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            dd_valid = 1'b0;
        end else begin
            k++;
            ph = ((k - 1) >> (BW - 1)) & 1;
            for (int i = 0; i < DIGITS; i++)
                exp_hex[8*i +: 8] = (m_blink[i] && ph == 1) ? 8'hFF : m_comm[8*i +: 8];
            if (k == acc + 5) m_comm = m_pend;
            if (load && !(k > acc && k < acc + 6)) begin
                acc     = k;
                m_pend  = display(value, dp, blank_lz);
                m_blink = blink_en;
                m_val   = value;
            end
            exp_busy = (k >= acc) && (k <= acc + 4);
            exp_done = (k == acc + 5);
            dd_valid = (k >= acc) && (k <= acc + 3);
            exp_dd   = dd_valid ? m_val[4*(k - acc) +: 4] : 4'h0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("hex", hex, exp_hex);
        check("busy", {31'h0, busy}, {31'h0, exp_busy});
        check("done", {31'h0, done}, {31'h0, exp_done});
        if (dd_valid) check("dec_data", {28'h0, dec_data}, {28'h0, exp_dd});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz, input logic [3:0] be);
        value    = v;
        dp       = d;
        blank_lz = lz;
        blink_en = be;
        load     = 1'b1;
        tick(1);
        load     = 1'b0;
    endtask

    task automatic count_window(input int n, output int nb, output int nd);
        nb = 0;
        nd = 0;
        repeat (n) begin
            @(negedge clk);
            nb += int'(busy);
            nd += int'(done);
        end
        tick(1);
    endtask

    initial begin
        int nb, nd, n_ff, n_on, n_other;

        // Reset state
        tick(2);
        check("rst_hex", hex, 32'hFFFF_FFFF);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_dec_data", {28'h0, dec_data}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // 0123 with leading-zero blanking
        do_load(16'h0123, 4'h0, 1'b1, 4'h0);
        count_window(10, nb, nd);
        check("t2_busy_cycles", nb, 5);
        check("t2_done_pulses", nd, 1);
        check("t2_hex", hex, 32'hFFF9_A4B0);

        // All-zero value, with and without blanking
        do_load(16'h0000, 4'h0, 1'b1, 4'h0);
        count_window(10, nb, nd);
        check("t3a_hex", hex, 32'hFFFF_FFC0);
        do_load(16'h0000, 4'h0, 1'b0, 4'h0);
        count_window(10, nb, nd);
        check("t3b_hex", hex, 32'hC0C0_C0C0);

        // ABCD with DP on digit 0, plus an ignored load while busy
        do_load(16'hABCD, 4'b0001, 1'b0, 4'h0);
        value = 16'h1111;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
        count_window(12, nb, nd);
        check("t4_done_pulses", nd, 1);
        check("t4_hex", hex, 32'h8883_C621);

        // Blink digit 2 with a 16-cycle period
        do_load(16'hABCD, 4'b0001, 1'b0, 4'b0100);
        tick(10);
        n_ff = 0; n_on = 0; n_other = 0;
        repeat (32) begin
            @(negedge clk);
            if (hex[23:16] == 8'hFF) n_ff++;
            if (hex[23:16] == 8'h83) n_on++;
            if ({hex[31:24], hex[15:0]} != 24'h88_C621) n_other++;
        end
        tick(1);
        check("t5_blink_off", n_ff, 16);
        check("t5_blink_on", n_on, 16);
        check("t5_steady", n_other, 0);

        // Load held high: continuous refresh, blanked top digits, F shown
        value    = 16'h00F0;
        dp       = 4'h0;
        blank_lz = 1'b1;
        blink_en = 4'h0;
        load     = 1'b1;
        tick(13);
        load     = 1'b0;
        tick(10);
        check("held_hex", hex, 32'hFFFF_8EC0);

        // Reset mid-scan, then a fresh load
        do_load(16'h4567, 4'hF, 1'b0, 4'h0);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_hex", hex, 32'hFFFF_FFFF);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        count_window(10, nb, nd);
        check("t6_idle_busy", nb, 0);
        check("t6_idle_done", nd, 0);
        check("t6_idle_hex", hex, 32'hFFFF_FFFF);
        do_load(16'h0456, 4'h0, 1'b1, 4'h0);
        count_window(10, nb, nd);
        check("t6_busy_cycles", nb, 5);
        check("t6_done_pulses", nd, 1);
        check("t6_hex", hex, 32'hFF99_9282);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
